// File: rtl/pifo_sched_pkg.sv
// Shared types and helpers for the PIFO scheduler/controller.
package pifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int CNT_WIDTH = 32;

    function automatic int pifo_depth(input int l2);
        return 1 << l2;
    endfunction

endpackage

// File: rtl/pifo_sched_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after i_ptr.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PW-1:0]        i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PW-1:0]        o_idx
);

    logic          w_found;
    logic [PW:0]   w_sum;

    // i_ptr < NUM_PORTS, so one conditional subtraction wraps the rotated index.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_PORTS))
                w_sum = w_sum - (PW+1)'(NUM_PORTS);
            if (!w_found && i_req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_sum[PW-1:0];
            end
        end
        if (w_found)
            o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/pifo_sched_ctrl.sv
// Arbitrates enqueue ports and sequences insert/remove pulses to a pifo_reg.
// Optional PIFO_SCHED_STATS_EN adds saturating drop/evict/replace counters.
module pifo_sched_ctrl
    import pifo_sched_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int L2_REG_WIDTH = 2,
    parameter int RANK_WIDTH   = 8,
    parameter int META_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            enq_valid,
    input  logic [NUM_PORTS*RANK_WIDTH-1:0] enq_rank,
    input  logic [NUM_PORTS*META_WIDTH-1:0] enq_meta,
    output logic [NUM_PORTS-1:0]            enq_ready,
    output logic                            deq_valid,
    input  logic                            deq_ready,
    output logic [RANK_WIDTH-1:0]           deq_rank,
    output logic [META_WIDTH-1:0]           deq_meta,
    output logic                            evict_valid,
    output logic [RANK_WIDTH-1:0]           evict_rank,
    output logic [META_WIDTH-1:0]           evict_meta,
    output logic                            drop,
    output logic                            busy,
`ifdef PIFO_SCHED_STATS_EN
    output logic [CNT_WIDTH-1:0]            drop_cnt,
    output logic [CNT_WIDTH-1:0]            evict_cnt,
    output logic [CNT_WIDTH-1:0]            replace_cnt,
`endif
    output logic                            pifo_insert,
    output logic                            pifo_remove,
    output logic [RANK_WIDTH-1:0]           pifo_rank_in,
    output logic [META_WIDTH-1:0]           pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]           pifo_rank_out,
    input  logic [META_WIDTH-1:0]           pifo_meta_out,
    input  logic                            pifo_valid_out,
    input  logic [RANK_WIDTH-1:0]           pifo_max_rank,
    input  logic [META_WIDTH-1:0]           pifo_max_meta,
    input  logic [L2_REG_WIDTH:0]           pifo_num_entries
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [L2_REG_WIDTH:0] DEPTH = (L2_REG_WIDTH+1)'(pifo_depth(L2_REG_WIDTH));

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic                  r_insert, r_remove, r_evict, r_drop;
    logic [RANK_WIDTH-1:0] r_rank_in, r_evict_rank;
    logic [META_WIDTH-1:0] r_meta_in, r_evict_meta;

    logic [NUM_PORTS-1:0]  w_grant;
    logic [PW-1:0]         w_gidx, w_ptr_next;
    logic                  w_idle, w_enq_hs, w_deq_hs, w_full_enq, w_lower;
    logic                  w_evict, w_drop;
    logic [RANK_WIDTH-1:0] w_sel_rank;
    logic [META_WIDTH-1:0] w_sel_meta;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
        .i_req   (enq_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign enq_ready  = w_idle ? w_grant : '0;
    assign deq_valid  = w_idle && pifo_valid_out && (pifo_num_entries != '0);
    assign deq_rank   = pifo_rank_out;
    assign deq_meta   = pifo_meta_out;

    assign w_enq_hs   = |(enq_valid & enq_ready);
    assign w_deq_hs   = deq_valid && deq_ready;
    assign w_sel_rank = enq_rank[w_gidx*RANK_WIDTH +: RANK_WIDTH];
    assign w_sel_meta = enq_meta[w_gidx*META_WIDTH +: META_WIDTH];
    assign w_ptr_next = (w_gidx == PW'(NUM_PORTS-1)) ? '0 : w_gidx + 1'b1;

    // A concurrent dequeue turns a full-PIFO enqueue into a replace-min, never a loss.
    assign w_full_enq = w_enq_hs && !w_deq_hs && (pifo_num_entries == DEPTH);
    assign w_lower    = w_sel_rank < pifo_max_rank;
    assign w_evict    = w_full_enq && w_lower;
    assign w_drop     = w_full_enq && !w_lower;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_insert     <= 1'b0;
            r_remove     <= 1'b0;
            r_evict      <= 1'b0;
            r_drop       <= 1'b0;
            r_rank_in    <= '0;
            r_meta_in    <= '0;
            r_evict_rank <= '0;
            r_evict_meta <= '0;
        end else begin
            r_insert <= 1'b0;
            r_remove <= 1'b0;
            r_evict  <= 1'b0;
            r_drop   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_enq_hs || w_deq_hs) begin
                        r_state  <= ST_ISSUE;
                        r_insert <= w_enq_hs;
                        r_remove <= w_deq_hs;
                        r_evict  <= w_evict;
                        r_drop   <= w_drop;
                        if (w_enq_hs) begin
                            r_rank_in <= w_sel_rank;
                            r_meta_in <= w_sel_meta;
                            r_ptr     <= w_ptr_next;
                        end
                        if (w_evict) begin
                            r_evict_rank <= pifo_max_rank;
                            r_evict_meta <= pifo_max_meta;
                        end
                    end
                end
                ST_ISSUE: r_state <= ST_SETTLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign pifo_insert  = r_insert;
    assign pifo_remove  = r_remove;
    assign pifo_rank_in = r_rank_in;
    assign pifo_meta_in = r_meta_in;
    assign evict_valid  = r_evict;
    assign evict_rank   = r_evict_rank;
    assign evict_meta   = r_evict_meta;
    assign drop         = r_drop;
    assign busy         = (r_state != ST_IDLE);

`ifdef PIFO_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] r_drop_cnt, r_evict_cnt, r_replace_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt    <= '0;
            r_evict_cnt   <= '0;
            r_replace_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_evict && (r_evict_cnt != '1))
                r_evict_cnt <= r_evict_cnt + 1'b1;
            if (w_enq_hs && w_deq_hs && (r_replace_cnt != '1))
                r_replace_cnt <= r_replace_cnt + 1'b1;
        end
    end

    assign drop_cnt    = r_drop_cnt;
    assign evict_cnt   = r_evict_cnt;
    assign replace_cnt = r_replace_cnt;
`endif

endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// Directed + random bench for pifo_sched_ctrl with a behavioural PIFO and scoreboard.
module tb_pifo_sched_ctrl;

    typedef struct {
        logic [7:0] r;
        logic [7:0] m;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  enq_valid = '0;
    logic [31:0] enq_rank = '0;
    logic [31:0] enq_meta = '0;
    logic [3:0]  enq_ready;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [7:0]  deq_rank, deq_meta;
    logic        evict_valid, drop, busy;
    logic [7:0]  evict_rank, evict_meta;
    logic        pifo_insert, pifo_remove;
    logic [7:0]  pifo_rank_in, pifo_meta_in;
    logic [7:0]  pifo_rank_out, pifo_meta_out;
    logic        pifo_valid_out;
    logic [7:0]  pifo_max_rank, pifo_max_meta;
    logic [2:0]  pifo_num_entries;
`ifdef PIFO_SCHED_STATS_EN
    logic [31:0] drop_cnt, evict_cnt, replace_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pifo_sched_ctrl #(.NUM_PORTS(4), .L2_REG_WIDTH(2), .RANK_WIDTH(8), .META_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_rank(enq_rank), .enq_meta(enq_meta), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
        .evict_valid(evict_valid), .evict_rank(evict_rank), .evict_meta(evict_meta),
        .drop(drop), .busy(busy),
`ifdef PIFO_SCHED_STATS_EN
        .drop_cnt(drop_cnt), .evict_cnt(evict_cnt), .replace_cnt(replace_cnt),
`endif
        .pifo_insert(pifo_insert), .pifo_remove(pifo_remove),
        .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
        .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out), .pifo_valid_out(pifo_valid_out),
        .pifo_max_rank(pifo_max_rank), .pifo_max_meta(pifo_max_meta),
        .pifo_num_entries(pifo_num_entries)
    );

    // Behavioural pifo_reg: sorted storage, registered outputs, replace-max on full insert.
    ent_t pq[$];

    task automatic stub_ins(input ent_t e);
        int pos;
        pos = pq.size();
        for (int i = pq.size() - 1; i >= 0; i--)
            if (pq[i].r > e.r) pos = i;
        pq.insert(pos, e);
    endtask

    always @(posedge clk) begin
        ent_t e;
        e.r = pifo_rank_in;
        e.m = pifo_meta_in;
        if (rst) begin
            pq.delete();
        end else if (pifo_insert && pifo_remove) begin
            if (pq.size() > 0) void'(pq.pop_front());
            stub_ins(e);
        end else if (pifo_remove) begin
            if (pq.size() > 0) void'(pq.pop_front());
        end else if (pifo_insert) begin
            if (pq.size() < 4) begin
                stub_ins(e);
            end else if (e.r < pq[pq.size()-1].r) begin
                void'(pq.pop_back());
                stub_ins(e);
            end
        end
        pifo_valid_out   <= (pq.size() > 0);
        pifo_rank_out    <= (pq.size() > 0) ? pq[0].r : 8'h0;
        pifo_meta_out    <= (pq.size() > 0) ? pq[0].m : 8'h0;
        pifo_max_rank    <= (pq.size() > 0) ? pq[pq.size()-1].r : 8'h0;
        pifo_max_meta    <= (pq.size() > 0) ? pq[pq.size()-1].m : 8'h0;
        pifo_num_entries <= 3'(pq.size());
    end

    // Scoreboard: unsorted arrival-order multiset; min = lowest rank, oldest first.
    ent_t mq[$];
    int   rr_ptr = 0;
    int   m_drops = 0, m_evicts = 0, m_replaces = 0;

    function automatic int m_min_idx();
        int b = 0;
        for (int i = 1; i < mq.size(); i++)
            if (mq[i].r < mq[b].r) b = i;
        return b;
    endfunction

    function automatic int m_max_idx();
        int b = 0;
        for (int i = 1; i < mq.size(); i++)
            if (mq[i].r >= mq[b].r) b = i;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr_ptr     = 0;
        m_drops    = 0;
        m_evicts   = 0;
        m_replaces = 0;
    endtask

    task automatic do_op(input logic [3:0] req, input logic [31:0] ranks,
                         input logic [31:0] metas, input logic dq);
        int   g, p;
        logic enq_hs, deq_hs, full, exp_ev, exp_dr;
        logic [3:0] exp_gnt;
        ent_t ne, mx, mn;
        for (int i = 0; i < 8 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", busy, 0);
        enq_valid = req;
        enq_rank  = ranks;
        enq_meta  = metas;
        deq_ready = dq;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            p = (rr_ptr + k) % 4;
            if (g < 0 && req[p]) g = p;
        end
        exp_gnt = (g >= 0) ? 4'(1 << g) : 4'h0;
        chk("enq_ready", enq_ready, exp_gnt);
        chk("deq_valid", deq_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            mn = mq[m_min_idx()];
            chk("deq_rank", deq_rank, mn.r);
            chk("deq_meta", deq_meta, mn.m);
        end
        enq_hs = (g >= 0);
        deq_hs = dq && (mq.size() > 0);
        ne.r = 8'h0;
        ne.m = 8'h0;
        if (enq_hs) begin
            ne.r = ranks[g*8 +: 8];
            ne.m = metas[g*8 +: 8];
        end
        full   = (mq.size() == 4);
        exp_ev = 1'b0;
        exp_dr = 1'b0;
        mx.r = 8'h0;
        mx.m = 8'h0;
        if (enq_hs && !deq_hs && full) begin
            mx = mq[m_max_idx()];
            if (ne.r < mx.r) exp_ev = 1'b1;
            else             exp_dr = 1'b1;
        end
        @(posedge clk); #1;
        if (enq_hs || deq_hs) begin
            chk("pifo_insert", pifo_insert, enq_hs);
            chk("pifo_remove", pifo_remove, deq_hs);
            chk("evict_valid", evict_valid, exp_ev);
            chk("drop", drop, exp_dr);
            chk("busy_issue", busy, 1);
            chk("enq_ready_busy", enq_ready, 0);
            chk("deq_valid_busy", deq_valid, 0);
            if (enq_hs) begin
                chk("pifo_rank_in", pifo_rank_in, ne.r);
                chk("pifo_meta_in", pifo_meta_in, ne.m);
            end
            if (exp_ev) begin
                chk("evict_rank", evict_rank, mx.r);
                chk("evict_meta", evict_meta, mx.m);
            end
            if (enq_hs && deq_hs) begin
                mq.delete(m_min_idx());
                mq.push_back(ne);
                m_replaces++;
            end else if (deq_hs) begin
                mq.delete(m_min_idx());
            end else if (!full) begin
                mq.push_back(ne);
            end else if (exp_ev) begin
                mq.delete(m_max_idx());
                mq.push_back(ne);
                m_evicts++;
            end else begin
                m_drops++;
            end
            if (enq_hs) rr_ptr = (g + 1) % 4;
            enq_valid = '0;
            deq_ready = 1'b0;
            @(posedge clk); #1;
            chk("insert_pulse", pifo_insert, 0);
            chk("remove_pulse", pifo_remove, 0);
            chk("evict_pulse", evict_valid, 0);
            chk("drop_pulse", drop, 0);
            chk("busy_settle", busy, 1);
            @(posedge clk); #1;
            chk("busy_done", busy, 0);
            chk("num_entries", pifo_num_entries, mq.size());
            chk("deq_valid_t3", deq_valid, mq.size() > 0);
            if (mq.size() > 0) chk("deq_rank_t3", deq_rank, mq[m_min_idx()].r);
        end else begin
            chk("pifo_remove_idle", pifo_remove, 0);
            chk("busy_idle", busy, 0);
            enq_valid = '0;
            deq_ready = 1'b0;
        end
`ifdef PIFO_SCHED_STATS_EN
        chk("drop_cnt", drop_cnt, m_drops);
        chk("evict_cnt", evict_cnt, m_evicts);
        chk("replace_cnt", replace_cnt, m_replaces);
`endif
        $display("txn req=%b dq=%0d grant=%0d enq=%0d deq=%0d evict=%0d drop=%0d entries=%0d",
                 req, dq, g, enq_hs, deq_hs, exp_ev, exp_dr, mq.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rq;
        logic [31:0] rk, mt;
        logic        dqr;

        // Reset state, with requests held high while rst is asserted.
        enq_valid = 4'hF;
        deq_ready = 1'b1;
        enq_rank  = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enq_ready", enq_ready, 0);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_insert", pifo_insert, 0);
        chk("rst_remove", pifo_remove, 0);
        chk("rst_evict", evict_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rank_in", pifo_rank_in, 0);
        chk("rst_evict_rank", evict_rank, 0);
        rst = 1'b0;
        enq_valid = '0;
        deq_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Single enqueue on port 2, then dequeue, then dequeue on empty.
        do_op(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 32'h44332211, 1'b0);
        do_op(4'b0000, 32'h0, 32'h0, 1'b1);
        do_op(4'b0000, 32'h0, 32'h0, 1'b1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Fairness fill to {3,7,9,12}, then drop, evict, replace-min, drain.
        repeat (4) do_op(4'hF, {8'd7, 8'd9, 8'd3, 8'd12}, 32'hD4C3B2A1, 1'b0);
        do_op(4'hF, {8'd7, 8'd9, 8'd3, 8'd12}, 32'h5A5A5A5A, 1'b0);
        do_op(4'hF, {8'd7, 8'd9, 8'd4, 8'd12}, 32'h11223344, 1'b0);
        do_op(4'hF, {8'd7, 8'd8, 8'd4, 8'd12}, 32'h99887766, 1'b1);
        repeat (4) do_op(4'h0, 32'h0, 32'h0, 1'b1);

        // Reset while in ISSUE.
        do_op(4'b0001, {8'd0, 8'd0, 8'd0, 8'd20}, 32'h000000EE, 1'b0);
        enq_valid = 4'b0100;
        enq_rank  = {8'd0, 8'd33, 8'd0, 8'd0};
        enq_meta  = 32'h00770000;
        #1;
        @(posedge clk); #1;
        chk("rst_issue_insert", pifo_insert, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rsti_enq_ready", enq_ready, 0);
        chk("rsti_deq_valid", deq_valid, 0);
        chk("rsti_insert", pifo_insert, 0);
        chk("rsti_busy", busy, 0);
        chk("rsti_rank_in", pifo_rank_in, 0);
        chk("rsti_meta_in", pifo_meta_in, 0);
        chk("rsti_evict_rank", evict_rank, 0);
        chk("rsti_evict_meta", evict_meta, 0);
`ifdef PIFO_SCHED_STATS_EN
        chk("rsti_drop_cnt", drop_cnt, 0);
        chk("rsti_evict_cnt", evict_cnt, 0);
        chk("rsti_replace_cnt", replace_cnt, 0);
`endif
        rst = 1'b0;
        enq_valid = '0;
        model_reset();
        @(posedge clk); #1;
        do_op(4'hF, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h01020304, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            rq  = 4'($urandom_range(0, 15));
            dqr = 1'($urandom_range(0, 1));
            if (rq == 4'h0 && !(dqr && mq.size() > 0))
                rq = 4'(1 << $urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                rk[k*8 +: 8] = 8'($urandom_range(0, 31));
                mt[k*8 +: 8] = 8'($urandom);
            end
            do_op(rq, rk, mt, dqr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
